// File: rtl/tim_etb_pkg.sv
// ---------------------------------------------------------------------------
// tim_etb_pkg
//   Shared definitions for the ETB trigger router: register word indexes
//   (paddr[5:2]), trigger source / destination encodings and the packed
//   per-channel configuration layout as it appears in CHn_CFG.
// ---------------------------------------------------------------------------
package tim_etb_pkg;

  localparam int NUM_SRC = 4;
  localparam int NUM_DST = 4;
  localparam int OVF_LSB = 4;  // OVF flags live in STATUS[7:4]

  // Register word indexes, i.e. byte offset >> 2.
  localparam logic [3:0] IDX_CTRL   = 4'h0;
  localparam logic [3:0] IDX_SWTRIG = 4'h1;
  localparam logic [3:0] IDX_STATUS = 4'h2;
  localparam logic [3:0] IDX_INTEN  = 4'h3;
  localparam logic [3:0] IDX_CFG0   = 4'h4;
  localparam logic [3:0] IDX_CNT0   = 4'h8;

  typedef enum logic [1:0] {
    SRC_TIM1 = 2'd0,
    SRC_TIM2 = 2'd1,
    SRC_EXT0 = 2'd2,
    SRC_EXT1 = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    DST_T1_ON  = 2'd0,
    DST_T1_OFF = 2'd1,
    DST_T2_ON  = 2'd2,
    DST_T2_OFF = 2'd3
  } dst_e;

  // Field order matches CHn_CFG: [4:3] DST, [2:1] SRC, [0] EN.
  typedef struct packed {
    dst_e dst;
    src_e src;
    logic en;
  } ch_cfg_t;

  localparam ch_cfg_t CFG_RESET = '{dst: DST_T1_ON, src: SRC_TIM1, en: 1'b0};

endpackage

// File: rtl/tim_etb_chan.sv
// ---------------------------------------------------------------------------
// tim_etb_chan
//   One routing channel: gates the selected trigger with the global and
//   channel enables, and keeps the sticky EVT/OVF flags and the wrapping
//   event counter.
// Ports
//   pclk, presetn   clock, async active-low reset
//   gen_i, en_i     global enable, channel enable
//   trig_i          selected hardware edge OR software trigger
//   evt_clr_i       W1C of EVT this cycle
//   ovf_clr_i       W1C of OVF this cycle
//   cnt_clr_i       write to CHn_CNT this cycle
//   ch_evt_o        qualified channel event (combinational)
//   evt_o, ovf_o    sticky flags
//   cnt_o           event counter
// ---------------------------------------------------------------------------
module tim_etb_chan
  import tim_etb_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             gen_i,
  input  logic             en_i,
  input  logic             trig_i,
  input  logic             evt_clr_i,
  input  logic             ovf_clr_i,
  input  logic             cnt_clr_i,
  output logic             ch_evt_o,
  output logic             evt_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic             evt_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  assign ch_evt_o = gen_i & en_i & trig_i;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      evt_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      // A new event beats a same-cycle W1C.
      evt_q <= ch_evt_o | (evt_q & ~evt_clr_i);
      // Overflow only if the flag being hit is not simultaneously cleared.
      ovf_q <= (ch_evt_o & evt_q & ~evt_clr_i) | (ovf_q & ~ovf_clr_i);
      // Clear-with-event lands on 1; plain increment wraps naturally.
      cnt_q <= cnt_clr_i ? CNT_W'(ch_evt_o) : cnt_q + CNT_W'(ch_evt_o);
    end
  end

  assign evt_o = evt_q;
  assign ovf_o = ovf_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/tim_etb_trig_router.sv
// ---------------------------------------------------------------------------
// tim_etb_trig_router
//   APB-programmable router from timer / external trigger edges to the
//   timers' start/stop strobes, with per-channel flags, counters and a
//   level interrupt.
// Ports
//   pclk, presetn          clock, async active-low reset
//   psel/penable/pwrite    APB control (zero wait states)
//   paddr, pwdata, prdata  APB address (only [5:2] decoded), write/read data
//   tim1_etb_trig          source 0
//   tim2_etb_trig          source 1
//   ext_trig_in[1:0]       sources 2 and 3 (already in pclk domain)
//   etb_tim*_trig_en_*     1-cycle registered strobes, destinations 0..3
//   intr                   |(EVT & INTEN)
// ---------------------------------------------------------------------------
module tim_etb_trig_router
  import tim_etb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  input  logic        tim1_etb_trig,
  input  logic        tim2_etb_trig,
  input  logic [1:0]  ext_trig_in,
  output logic        etb_tim1_trig_en_on,
  output logic        etb_tim1_trig_en_off,
  output logic        etb_tim2_trig_en_on,
  output logic        etb_tim2_trig_en_off,
  output logic        intr
);

  logic               wr_en;
  logic               rd_en;
  logic [3:0]         idx;

  logic               gen_q;
  logic [NUM_CH-1:0]  inten_q;
  ch_cfg_t            cfg_q [NUM_CH];
  logic [NUM_SRC-1:0] src;
  logic [NUM_SRC-1:0] src_d_q;
  logic [NUM_SRC-1:0] hw_evt;
  logic [NUM_DST-1:0] dst_d;
  logic [NUM_DST-1:0] dst_q;

  logic [NUM_CH-1:0]  swtrig_wr;
  logic [NUM_CH-1:0]  evt_clr;
  logic [NUM_CH-1:0]  ovf_clr;
  logic [NUM_CH-1:0]  cnt_clr;
  logic [NUM_CH-1:0]  ch_trig;
  logic [NUM_CH-1:0]  ch_evt;
  logic [NUM_CH-1:0]  evt;
  logic [NUM_CH-1:0]  ovf;
  logic [CNT_W-1:0]   cnt [NUM_CH];

  // Address/data bits outside the register map are intentionally ignored.
  logic unused_apb;
  assign unused_apb = ^{paddr[31:6], paddr[1:0], pwdata[31:8]};

  assign wr_en = psel & penable & pwrite;
  assign rd_en = psel & penable & ~pwrite;
  assign idx   = paddr[5:2];

  // Bit order follows the SRC encoding.
  assign src    = {ext_trig_in, tim2_etb_trig, tim1_etb_trig};
  assign hw_evt = src & ~src_d_q;

  assign swtrig_wr = (wr_en && idx == IDX_SWTRIG) ? pwdata[NUM_CH-1:0] : '0;
  assign evt_clr   = (wr_en && idx == IDX_STATUS) ? pwdata[NUM_CH-1:0] : '0;
  assign ovf_clr   = (wr_en && idx == IDX_STATUS) ? pwdata[OVF_LSB +: NUM_CH] : '0;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign cnt_clr[n] = wr_en && (idx == IDX_CNT0 + 4'(n));
    assign ch_trig[n] = hw_evt[cfg_q[n].src] | swtrig_wr[n];

    tim_etb_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .pclk      (pclk),
      .presetn   (presetn),
      .gen_i     (gen_q),
      .en_i      (cfg_q[n].en),
      .trig_i    (ch_trig[n]),
      .evt_clr_i (evt_clr[n]),
      .ovf_clr_i (ovf_clr[n]),
      .cnt_clr_i (cnt_clr[n]),
      .ch_evt_o  (ch_evt[n]),
      .evt_o     (evt[n]),
      .ovf_o     (ovf[n]),
      .cnt_o     (cnt[n])
    );
  end

  // Channels sharing a destination merge into one strobe.
  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dst_d = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_evt[n]) dst_d[cfg_q[n].dst] = 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      gen_q   <= 1'b0;
      inten_q <= '0;
      src_d_q <= '0;
      dst_q   <= '0;
      for (int n = 0; n < NUM_CH; n++) cfg_q[n] <= CFG_RESET;
    end else begin
      // Edge detectors track the sources even while routing is disabled,
      // so enabling with a source already high produces no event.
      src_d_q <= src;
      dst_q   <= dst_d;
      if (wr_en) begin
        if (idx == IDX_CTRL)  gen_q   <= pwdata[0];
        if (idx == IDX_INTEN) inten_q <= pwdata[NUM_CH-1:0];
        for (int n = 0; n < NUM_CH; n++) begin
          if (idx == IDX_CFG0 + 4'(n)) cfg_q[n] <= ch_cfg_t'(pwdata[4:0]);
        end
      end
    end
  end

  always_comb begin
    prdata = '0;
    if (rd_en) begin
      case (idx)
        IDX_CTRL:   prdata[0] = gen_q;
        IDX_STATUS: begin
          prdata[NUM_CH-1:0]         = evt;
          prdata[OVF_LSB +: NUM_CH]  = ovf;
        end
        IDX_INTEN:  prdata[NUM_CH-1:0] = inten_q;
        default:    ;
      endcase
      for (int n = 0; n < NUM_CH; n++) begin
        if (idx == IDX_CFG0 + 4'(n)) prdata[4:0]       = cfg_q[n];
        if (idx == IDX_CNT0 + 4'(n)) prdata[CNT_W-1:0] = cnt[n];
      end
    end
  end

  assign etb_tim1_trig_en_on  = dst_q[DST_T1_ON];
  assign etb_tim1_trig_en_off = dst_q[DST_T1_OFF];
  assign etb_tim2_trig_en_on  = dst_q[DST_T2_ON];
  assign etb_tim2_trig_en_off = dst_q[DST_T2_OFF];

  assign intr = |(evt & inten_q);

endmodule

// File: tb/tb_tim_etb_trig_router.sv
// ---------------------------------------------------------------------------
// tb_tim_etb_trig_router
//   Directed scenarios plus a randomized run against a cycle-level model of
//   the router's register and event rules.
// ---------------------------------------------------------------------------
module tb_tim_etb_trig_router;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  src_drv;  // {ext1, ext0, tim2, tim1}
  logic        on1, off1, on2, off2, intr;
  logic [3:0]  strobes;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  tim_etb_trig_router #(
    .NUM_CH(NUM_CH),
    .CNT_W (CNT_W)
  ) dut (
    .pclk                 (pclk),
    .presetn              (presetn),
    .psel                 (psel),
    .penable              (penable),
    .pwrite               (pwrite),
    .paddr                (paddr),
    .pwdata               (pwdata),
    .prdata               (prdata),
    .tim1_etb_trig        (src_drv[0]),
    .tim2_etb_trig        (src_drv[1]),
    .ext_trig_in          (src_drv[3:2]),
    .etb_tim1_trig_en_on  (on1),
    .etb_tim1_trig_en_off (off1),
    .etb_tim2_trig_en_on  (on2),
    .etb_tim2_trig_en_off (off2),
    .intr                 (intr)
  );

  assign strobes = {off2, on2, off1, on1};

  // ---------------- reference model ----------------
  typedef struct packed {
    logic            gen;
    logic [3:0]      inten;
    logic [3:0]      en;
    logic [3:0][1:0] src;
    logic [3:0][1:0] dst;
    logic [3:0]      prev;
    logic [3:0]      evt;
    logic [3:0]      ovf;
    logic [3:0][15:0] cnt;
    logic [3:0]      strobe;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t cur, logic wr, logic [3:0] idx,
                                        logic [31:0] wd, logic [3:0] srcs);
    model_t     nx;
    logic [3:0] rose;
    logic [3:0] ev;
    logic       sw, clr_e, clr_o, cclr;
    nx = cur;
    for (int s = 0; s < 4; s++) rose[s] = srcs[s] && !cur.prev[s];
    for (int n = 0; n < 4; n++) begin
      sw    = wr && int'(idx) == 1 && wd[n];
      ev[n] = cur.gen && cur.en[n] && (rose[cur.src[n]] || sw);
    end
    nx.strobe = '0;
    for (int n = 0; n < 4; n++) if (ev[n]) nx.strobe[cur.dst[n]] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      clr_e = wr && int'(idx) == 2 && wd[n];
      clr_o = wr && int'(idx) == 2 && wd[4+n];
      cclr  = wr && int'(idx) == 8 + n;
      if (ev[n] && cur.evt[n] && !clr_e) nx.ovf[n] = 1'b1;
      else if (clr_o)                    nx.ovf[n] = 1'b0;
      if (ev[n])      nx.evt[n] = 1'b1;
      else if (clr_e) nx.evt[n] = 1'b0;
      if (cclr)       nx.cnt[n] = ev[n] ? 16'd1 : 16'd0;
      else if (ev[n]) nx.cnt[n] = 16'((int'(cur.cnt[n]) + 1) % 65536);
    end
    if (wr) begin
      if (int'(idx) == 0) nx.gen   = wd[0];
      if (int'(idx) == 3) nx.inten = wd[3:0];
      for (int n = 0; n < 4; n++) begin
        if (int'(idx) == 4 + n) begin
          nx.en[n]  = wd[0];
          nx.src[n] = wd[2:1];
          nx.dst[n] = wd[4:3];
        end
      end
    end
    nx.prev = srcs;
    return nx;
  endfunction

  function automatic logic [31:0] model_read(model_t cur, logic [3:0] idx);
    int i;
    i = int'(idx);
    if (i == 0) return {31'b0, cur.gen};
    if (i == 2) return {24'b0, cur.ovf, cur.evt};
    if (i == 3) return {28'b0, cur.inten};
    if (i >= 4 && i <= 7) return {27'b0, cur.dst[i-4], cur.src[i-4], cur.en[i-4]};
    if (i >= 8 && i <= 11) return {16'b0, cur.cnt[i-8]};
    return 32'h0;
  endfunction

  always @(posedge pclk or negedge presetn) begin
    if (!presetn) m <= '0;
    else          m <= model_next(m, psel && penable && pwrite, paddr[5:2], pwdata, src_drv);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // trig is OR-ed onto the sources during the access cycle only.
  task automatic apb_write(input logic [3:0] idx, input logic [31:0] data, input logic [3:0] trig);
    logic [3:0] keep;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = {26'b0, idx, 2'b00}; pwdata = data;
    tick();
    penable = 1'b1; keep = src_drv; src_drv = keep | trig;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; src_drv = keep;
  endtask

  task automatic apb_read(input logic [3:0] idx, output logic [31:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = {26'b0, idx, 2'b00};
    tick();
    penable = 1'b1;
    @(negedge pclk);
    data = prdata;
    @(posedge pclk);
    #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; src_drv = '0;
    #12;
    checks++; if (strobes !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b exp 0000", strobes); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL reset_intr got %b exp 0", intr); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata got %h exp 0", prdata); end
    @(negedge pclk);
    presetn = 1'b1;
    tick();
    apb_read(4'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", rd); end
    apb_read(4'h2, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL reset_status got %h exp 0", rd); end
  endtask

  task automatic test_single_edge();
    logic [31:0] rd;
    logic [3:0]  exp;
    apb_write(4'h0, 32'h1, 4'h0);
    apb_write(4'h4, 32'h01, 4'h0);  // CH0: EN, SRC=TIM1, DST=T1_ON
    apb_write(4'h3, 32'h1, 4'h0);
    src_drv[0] = 1'b1;
    @(negedge pclk);
    checks++; if (strobes !== 4'b0) begin errors++; $display("FAIL t1_same_cycle got %b exp 0000", strobes); end
    tick();
    for (int c = 1; c <= 6; c++) begin
      if (c == 5) src_drv[0] = 1'b0;
      exp = (c == 1) ? 4'b0001 : 4'b0000;
      @(negedge pclk);
      checks++; if (strobes !== exp) begin errors++; $display("FAIL t1_strobe_c%0d got %b exp %b", c, strobes, exp); end
      tick();
    end
    apb_read(4'h2, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL t1_status got %h exp 1", rd); end
    apb_read(4'h8, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL t1_cnt0 got %h exp 1", rd); end
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL t1_intr got %b exp 1", intr); end
  endtask

  task automatic test_merge();
    logic [31:0] rd;
    apb_write(4'h8, 32'h0, 4'h0);    // clear CNT0
    apb_write(4'h4, 32'h19, 4'h0);   // CH0: EN, SRC=TIM1, DST=T2_OFF
    apb_write(4'h5, 32'h1B, 4'h0);   // CH1: EN, SRC=TIM2, DST=T2_OFF
    src_drv[1:0] = 2'b11;
    tick();
    @(negedge pclk);
    checks++; if (strobes !== 4'b1000) begin errors++; $display("FAIL t2_merge got %b exp 1000", strobes); end
    src_drv[1:0] = 2'b00;
    tick();
    @(negedge pclk);
    checks++; if (strobes !== 4'b0000) begin errors++; $display("FAIL t2_merge_end got %b exp 0000", strobes); end
    tick();
    apb_read(4'h8, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL t2_cnt0 got %h exp 1", rd); end
    apb_read(4'h9, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL t2_cnt1 got %h exp 1", rd); end
  endtask

  task automatic test_overflow_w1c();
    logic [31:0] rd;
    apb_write(4'h3, 32'h4, 4'h0);   // INTEN only CH2
    apb_write(4'h6, 32'h0F, 4'h0);  // CH2: EN, SRC=EXT1, DST=T1_OFF
    for (int p = 0; p < 2; p++) begin
      src_drv[3] = 1'b1;
      tick();
      src_drv[3] = 1'b0;
      @(negedge pclk);
      checks++; if (strobes !== 4'b0010) begin errors++; $display("FAIL t3_strobe_p%0d got %b exp 0010", p, strobes); end
      tick();
    end
    apb_read(4'h2, rd);
    checks++; if ((rd & 32'h44) !== 32'h44) begin errors++; $display("FAIL t3_ovf_set got %h exp 44", rd & 32'h44); end
    checks++; if (intr !== 1'b1) begin errors++; $display("FAIL t3_intr_set got %b exp 1", intr); end
    apb_write(4'h2, 32'h44, 4'h0);
    apb_read(4'h2, rd);
    checks++; if ((rd & 32'h44) !== 32'h0) begin errors++; $display("FAIL t3_w1c got %h exp 0", rd & 32'h44); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL t3_intr_clr got %b exp 0", intr); end
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd;
    apb_write(4'h2, 32'h2, 4'b0010);  // W1C EVT[1] with CH1 event
    apb_read(4'h2, rd);
    checks++; if (rd[1] !== 1'b1) begin errors++; $display("FAIL t4_evt1_kept got %b exp 1", rd[1]); end
    checks++; if (rd[5] !== 1'b0) begin errors++; $display("FAIL t4_ovf1 got %b exp 0", rd[5]); end
    apb_write(4'h9, 32'h0, 4'b0010);  // clear CNT1 with CH1 event
    apb_read(4'h9, rd);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL t4_cnt1 got %h exp 1", rd); end
  endtask

  task automatic test_gen_gating();
    logic [31:0] rd;
    model_t      snap;
    apb_write(4'h0, 32'h0, 4'h0);
    snap = m;
    apb_write(4'h1, 32'hF, 4'b1100);
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      checks++; if (strobes !== 4'b0) begin errors++; $display("FAIL t5_gen0_c%0d got %b exp 0000", c, strobes); end
      tick();
    end
    apb_read(4'h2, rd);
    checks++; if (rd !== {24'b0, snap.ovf, snap.evt}) begin errors++; $display("FAIL t5_status got %h exp %h", rd, {24'b0, snap.ovf, snap.evt}); end
    for (int n = 0; n < 4; n++) begin
      apb_read(4'(8 + n), rd);
      checks++; if (rd !== {16'b0, snap.cnt[n]}) begin errors++; $display("FAIL t5_cnt%0d got %h exp %h", n, rd, snap.cnt[n]); end
    end
    apb_write(4'h6, 32'h15, 4'h0);  // CH2: EN, SRC=EXT0, DST=T2_ON
    src_drv[2] = 1'b1;
    tick();
    tick();
    apb_write(4'h0, 32'h1, 4'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge pclk);
      checks++; if (strobes !== 4'b0) begin errors++; $display("FAIL t5_held_c%0d got %b exp 0000", c, strobes); end
      tick();
    end
    apb_read(4'hA, rd);
    checks++; if (rd !== {16'b0, snap.cnt[2]}) begin errors++; $display("FAIL t5_cnt2_held got %h exp %h", rd, snap.cnt[2]); end
    src_drv[2] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int          phase;
    logic [3:0]  ridx;
    logic [31:0] rdat;
    logic [31:0] exp_rd;
    logic        exp_intr;
    apb_write(4'h0, 32'h1, 4'h0);
    for (int n = 0; n < 4; n++) apb_write(4'(4 + n), {27'b0, 5'($urandom) | 5'd1}, 4'h0);
    phase = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (phase == 0) begin
        if ($urandom_range(0, 2) == 0) begin
          ridx = 4'($urandom_range(0, 15));
          case (ridx)
            4'h0:                      rdat = ($urandom_range(0, 4) != 0) ? 32'h1 : 32'h0;
            4'h4, 4'h5, 4'h6, 4'h7:    rdat = $urandom | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
            default:                   rdat = $urandom;
          endcase
          psel = 1'b1; penable = 1'b0; pwrite = 1'($urandom_range(0, 1));
          paddr = {26'b0, ridx, 2'b00}; pwdata = rdat;
          phase = 1;
        end
      end else if (phase == 1) begin
        penable = 1'b1;
        phase = 2;
      end
      for (int s = 0; s < 4; s++) if ($urandom_range(0, 3) == 0) src_drv[s] = ~src_drv[s];
      @(negedge pclk);
      exp_intr = |(m.evt & m.inten);
      exp_rd   = (psel && penable && !pwrite) ? model_read(m, paddr[5:2]) : 32'h0;
      checks++; if (strobes !== m.strobe) begin errors++; $display("FAIL rnd_strobe cyc %0d got %b exp %b", cyc, strobes, m.strobe); end
      checks++; if (intr !== exp_intr) begin errors++; $display("FAIL rnd_intr cyc %0d got %b exp %b", cyc, intr, exp_intr); end
      checks++; if (prdata !== exp_rd) begin errors++; $display("FAIL rnd_prdata cyc %0d idx %0d got %h exp %h", cyc, paddr[5:2], prdata, exp_rd); end
      tick();
      if (phase == 2) begin
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        phase = 0;
      end
    end
    src_drv = '0;
    tick();
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] rd;
    apb_write(4'h0, 32'h1, 4'h0);
    apb_write(4'h7, 32'h01, 4'h0);  // CH3: EN, SRC=TIM1, DST=T1_ON
    apb_write(4'hB, 32'h0, 4'h0);   // clear CNT3
    // Back-to-back access cycles: one SWTRIG event on CH3 per clock.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'h8;
    tick();
    penable = 1'b1;
    repeat (65535) tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb_read(4'hB, rd);
    checks++; if (rd !== 32'hFFFF) begin errors++; $display("FAIL t6_cnt_full got %h exp ffff", rd); end
    apb_write(4'h1, 32'h8, 4'h0);
    apb_read(4'hB, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL t6_cnt_wrap got %h exp 0", rd); end
    apb_write(4'h1, 32'h8, 4'h0);
    @(negedge pclk);
    checks++; if (strobes !== 4'b0001) begin errors++; $display("FAIL t6_pre_reset got %b exp 0001", strobes); end
    presetn = 1'b0;
    #1;
    checks++; if (strobes !== 4'b0000) begin errors++; $display("FAIL t6_reset_strobe got %b exp 0000", strobes); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL t6_reset_intr got %b exp 0", intr); end
    @(negedge pclk);
    presetn = 1'b1;
    tick();
    apb_read(4'h0, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL t6_ctrl_after got %h exp 0", rd); end
    apb_read(4'hB, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL t6_cnt_after got %h exp 0", rd); end
  endtask

  initial begin
    test_reset();
    test_single_edge();
    test_merge();
    test_overflow_w1c();
    test_w1c_race();
    test_gen_gating();
    test_random();
    test_wrap_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
